// File: rtl/alu_ctrl_pkg.sv
// Shared encodings and FSM state type for the RV32 ALU control sequencer.
package alu_ctrl_pkg;

    localparam int unsigned AluOpW = 4;

    localparam logic [AluOpW-1:0] OpAnd   = 4'b0000;
    localparam logic [AluOpW-1:0] OpOr    = 4'b0001;
    localparam logic [AluOpW-1:0] OpAdd   = 4'b0010;
    localparam logic [AluOpW-1:0] OpXor   = 4'b0101;
    localparam logic [AluOpW-1:0] OpSub   = 4'b0110;
    localparam logic [AluOpW-1:0] OpSrl   = 4'b1000;
    localparam logic [AluOpW-1:0] OpSra   = 4'b1001;
    localparam logic [AluOpW-1:0] OpSll   = 4'b1010;
    localparam logic [AluOpW-1:0] OpSlt   = 4'b1100;
    localparam logic [AluOpW-1:0] OpSltu  = 4'b1101;
    localparam logic [AluOpW-1:0] OpPassB = 4'b1111;

    localparam logic [1:0] AluOpMem    = 2'b00;
    localparam logic [1:0] AluOpBranch = 2'b01;
    localparam logic [1:0] AluOpArith  = 2'b10;
    localparam logic [1:0] AluOpPassB  = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StMdWait = 2'd1,
        StOut    = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of ALU_Op/funct3/funct7 into ALU op code, mul/div select and illegal flag.
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [1:0]        alu_op_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic              is_imm_i,
    output logic [AluOpW-1:0] op_o,
    output logic              is_md_o,
    output logic              illegal_o
);

    logic f7_checked;
    logic f7_alt_ok;

    always_comb begin
        op_o       = OpAdd;
        is_md_o    = 1'b0;
        illegal_o  = 1'b0;
        // I-type funct7 carries immediate bits except for the shift-immediates.
        f7_checked = !is_imm_i || (funct3_i == 3'd1) || (funct3_i == 3'd5);
        f7_alt_ok  = ((funct3_i == 3'd0) && !is_imm_i) || (funct3_i == 3'd5);

        unique case (alu_op_i)
            AluOpMem:   op_o = OpAdd;
            AluOpPassB: op_o = OpPassB;
            AluOpBranch: begin
                unique case (funct3_i)
                    3'd0, 3'd1: op_o = OpSub;
                    3'd4, 3'd5: op_o = OpSlt;
                    3'd6, 3'd7: op_o = OpSltu;
                    default:    illegal_o = 1'b1;
                endcase
            end
            default: begin
                unique case (funct3_i)
                    3'd0:    op_o = (!is_imm_i && (funct7_i == F7_ALT)) ? OpSub : OpAdd;
                    3'd1:    op_o = OpSll;
                    3'd2:    op_o = OpSlt;
                    3'd3:    op_o = OpSltu;
                    3'd4:    op_o = OpXor;
                    3'd5:    op_o = (funct7_i == F7_ALT) ? OpSra : OpSrl;
                    3'd6:    op_o = OpOr;
                    default: op_o = OpAnd;
                endcase
                if (f7_checked) begin
                    if ((funct7_i == F7_MULDIV) && !is_imm_i && ENABLE_M) begin
                        is_md_o = 1'b1;
                    end else if (!((funct7_i == F7_BASE) ||
                                   ((funct7_i == F7_ALT) && f7_alt_ok))) begin
                        illegal_o = 1'b1;
                    end
                end
            end
        endcase

        if (illegal_o || is_md_o) begin
            op_o = OpAdd;
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: valid/ready decode with registered outputs and mul/div start/done
// sequencing guarded by a watchdog.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter bit          ENABLE_M   = 1'b1,
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned OP_W       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic            is_imm_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out_op,
    output logic            out_sel_md,
    output logic            out_illegal,
    output logic            out_timeout,
    output logic            md_start,
    output logic [2:0]      md_op,
    output logic            md_abort,
    input  logic            md_done
);

    localparam int unsigned CntW = $clog2(MD_TIMEOUT);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              sel_md_q, sel_md_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;
    logic              md_start_q, md_start_d;
    logic [2:0]        md_op_q, md_op_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [AluOpW-1:0] dec_op;
    logic              dec_is_md;
    logic              dec_illegal;
    logic              accept;

    alu_op_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .alu_op_i  (alu_op_i),
        .funct3_i  (funct3_i),
        .funct7_i  (funct7_i),
        .is_imm_i  (is_imm_i),
        .op_o      (dec_op),
        .is_md_o   (dec_is_md),
        .illegal_o (dec_illegal)
    );

    assign in_ready = rst_n & ((state_q == StIdle) | ((state_q == StOut) & out_ready));
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sel_md_d   = sel_md_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        md_start_d = 1'b0;
        md_op_d    = md_op_q;
        cnt_d      = cnt_q;
        md_abort   = 1'b0;

        unique case (state_q)
            StIdle, StOut: begin
                if (accept) begin
                    op_d      = OP_W'(dec_op);
                    illegal_d = dec_illegal;
                    timeout_d = 1'b0;
                    sel_md_d  = 1'b0;
                    if (dec_is_md) begin
                        state_d    = StMdWait;
                        md_start_d = 1'b1;
                        md_op_d    = funct3_i;
                        cnt_d      = '0;
                    end else begin
                        state_d = StOut;
                    end
                end else if ((state_q == StOut) && out_ready) begin
                    state_d = StIdle;
                end
            end
            StMdWait: begin
                cnt_d = cnt_q + CntW'(1);
                if (md_done) begin
                    state_d  = StOut;
                    sel_md_d = 1'b1;
                    op_d     = OP_W'(OpAdd);
                    md_op_d  = '0;
                end else if (cnt_q == CntW'(MD_TIMEOUT - 1)) begin
                    // Abort is combinational so a done arriving in the timeout cycle can still win.
                    md_abort  = 1'b1;
                    state_d   = StOut;
                    sel_md_d  = 1'b1;
                    timeout_d = 1'b1;
                    op_d      = OP_W'(OpAdd);
                    md_op_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= '0;
            sel_md_q   <= 1'b0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
            md_start_q <= 1'b0;
            md_op_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sel_md_q   <= sel_md_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
            md_start_q <= md_start_d;
            md_op_q    <= md_op_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid   = (state_q == StOut);
    assign out_op      = op_q;
    assign out_sel_md  = sel_md_q;
    assign out_illegal = illegal_q;
    assign out_timeout = timeout_q;
    assign md_start    = md_start_q;
    assign md_op       = md_op_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: three instances (M on/64, M on/timeout 8, M off) share stimulus.
module tb_alu_ctrl_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] alu_op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_imm;
    logic       out_ready;
    logic       md_done;

    logic       rdy_a, ov_a, sel_a, ill_a, to_a, ms_a, ab_a;
    logic [3:0] op_a;
    logic [2:0] mop_a;
    logic       rdy_b, ov_b, sel_b, ill_b, to_b, ms_b, ab_b;
    logic [3:0] op_b;
    logic [2:0] mop_b;
    logic       rdy_c, ov_c, sel_c, ill_c, to_c, ms_c, ab_c;
    logic [3:0] op_c;
    logic [2:0] mop_c;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [1:0] aop;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       imm;
        logic [3:0] op;
        logic       ill;
    } vec_t;

    localparam int NVec = 17;
    vec_t vecs[NVec];

    alu_ctrl_seq #(.ENABLE_M(1'b1), .MD_TIMEOUT(64), .OP_W(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
        .alu_op_i(alu_op), .funct3_i(f3), .funct7_i(f7), .is_imm_i(is_imm),
        .out_valid(ov_a), .out_ready(out_ready), .out_op(op_a), .out_sel_md(sel_a),
        .out_illegal(ill_a), .out_timeout(to_a), .md_start(ms_a), .md_op(mop_a),
        .md_abort(ab_a), .md_done(md_done)
    );

    alu_ctrl_seq #(.ENABLE_M(1'b1), .MD_TIMEOUT(8), .OP_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
        .alu_op_i(alu_op), .funct3_i(f3), .funct7_i(f7), .is_imm_i(is_imm),
        .out_valid(ov_b), .out_ready(out_ready), .out_op(op_b), .out_sel_md(sel_b),
        .out_illegal(ill_b), .out_timeout(to_b), .md_start(ms_b), .md_op(mop_b),
        .md_abort(ab_b), .md_done(md_done)
    );

    alu_ctrl_seq #(.ENABLE_M(1'b0), .MD_TIMEOUT(64), .OP_W(4)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c),
        .alu_op_i(alu_op), .funct3_i(f3), .funct7_i(f7), .is_imm_i(is_imm),
        .out_valid(ov_c), .out_ready(out_ready), .out_op(op_c), .out_sel_md(sel_c),
        .out_illegal(ill_c), .out_timeout(to_c), .md_start(ms_c), .md_op(mop_c),
        .md_abort(ab_c), .md_done(md_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] a, input logic [2:0] f, input logic [6:0] s,
                         input logic imm);
        in_valid = 1'b1;
        alu_op   = a;
        f3       = f;
        f7       = s;
        is_imm   = imm;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vecs = '{
            '{2'b10, 3'd0, 7'h20, 1'b0, 4'b0110, 1'b0},  // sub
            '{2'b10, 3'd0, 7'h20, 1'b1, 4'b0010, 1'b0},  // addi, funct7 is immediate
            '{2'b10, 3'd5, 7'h20, 1'b1, 4'b1001, 1'b0},  // srai
            '{2'b01, 3'd6, 7'h00, 1'b0, 4'b1101, 1'b0},  // bltu
            '{2'b11, 3'd0, 7'h00, 1'b0, 4'b1111, 1'b0},  // lui
            '{2'b10, 3'd4, 7'h00, 1'b0, 4'b0101, 1'b0},  // xor
            '{2'b10, 3'd1, 7'h20, 1'b1, 4'b0010, 1'b1},  // slli with alt funct7
            '{2'b10, 3'd7, 7'h00, 1'b0, 4'b0000, 1'b0},  // and
            '{2'b01, 3'd2, 7'h00, 1'b0, 4'b0010, 1'b1},  // branch f3=2
            '{2'b10, 3'd2, 7'h20, 1'b0, 4'b0010, 1'b1},  // slt with alt funct7
            '{2'b10, 3'd1, 7'h00, 1'b0, 4'b1010, 1'b0},  // sll
            '{2'b10, 3'd5, 7'h00, 1'b0, 4'b1000, 1'b0},  // srl
            '{2'b10, 3'd6, 7'h7f, 1'b1, 4'b0001, 1'b0},  // ori
            '{2'b01, 3'd1, 7'h00, 1'b0, 4'b0110, 1'b0},  // bne
            '{2'b10, 3'd3, 7'h55, 1'b1, 4'b1101, 1'b0},  // sltiu
            '{2'b00, 3'd3, 7'h7f, 1'b0, 4'b0010, 1'b0},  // load
            '{2'b01, 3'd4, 7'h00, 1'b0, 4'b1100, 1'b0}   // blt
        };

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        alu_op    = 2'b00;
        f3        = 3'd0;
        f7        = 7'd0;
        is_imm    = 1'b0;
        out_ready = 1'b1;
        md_done   = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_in_ready", rdy_a, 1'b0);
        chk("rst_out_valid", ov_a, 1'b0);
        chk("rst_out_op", op_a, 4'd0);
        chk("rst_md_start", ms_a, 1'b0);
        chk("rst_md_abort", ab_a, 1'b0);
        chk("rst_flags", {sel_a, ill_a, to_a, mop_a}, 6'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", rdy_a, 1'b1);
        chk("rel_out_valid", ov_a, 1'b0);

        // Back-to-back decode, one result per cycle
        step();
        for (int i = 0; i <= NVec; i++) begin
            if (i < NVec) drive(vecs[i].aop, vecs[i].f3, vecs[i].f7, vecs[i].imm);
            else in_valid = 1'b0;
            #1;
            if (i == 0) begin
                chk("b2b_first_ready", rdy_a, 1'b1);
            end else begin
                chk($sformatf("b2b_valid_%0d", i - 1), ov_a, 1'b1);
                chk($sformatf("b2b_op_%0d", i - 1), op_a, vecs[i - 1].op);
                chk($sformatf("b2b_ill_%0d", i - 1), ill_a, vecs[i - 1].ill);
                chk($sformatf("b2b_sel_%0d", i - 1), sel_a, 1'b0);
                chk($sformatf("b2b_ready_%0d", i - 1), rdy_a, 1'b1);
            end
            step();
        end
        chk("b2b_idle_valid", ov_a, 1'b0);

        // DIV with md_done in wait cycle 10
        drive(2'b10, 3'd4, 7'b0000001, 1'b0);
        #1;
        chk("div_accept_ready", rdy_a, 1'b1);
        step();
        in_valid = 1'b0;
        #1;
        chk("div_md_start", ms_a, 1'b1);
        chk("div_md_op", mop_a, 3'b100);
        chk("div_out_valid_wait", ov_a, 1'b0);
        chk("nom_md_start", ms_c, 1'b0);
        chk("nom_out_valid", ov_c, 1'b1);
        chk("nom_illegal", ill_c, 1'b1);
        chk("nom_op", op_c, 4'b0010);
        step();
        chk("div_md_start_pulse", ms_a, 1'b0);
        for (int k = 3; k <= 9; k++) step();
        chk("div_no_abort", ab_a, 1'b0);
        chk("div_md_op_held", mop_a, 3'b100);
        step();
        md_done = 1'b1;
        #1;
        chk("div_valid_at_done", ov_a, 1'b0);
        step();
        md_done = 1'b0;
        #1;
        chk("div_out_valid", ov_a, 1'b1);
        chk("div_sel_md", sel_a, 1'b1);
        chk("div_timeout", to_a, 1'b0);
        chk("div_illegal", ill_a, 1'b0);
        chk("div_op", op_a, 4'b0010);
        chk("stray_done_ignored", ov_b, 1'b0);
        step();
        chk("div_idle", ov_a, 1'b0);

        // Watchdog timeout on the MD_TIMEOUT=8 instance, then done coincident with timeout
        for (int run = 0; run < 2; run++) begin
            step();
            drive(2'b10, 3'd0, 7'b0000001, 1'b0);
            #1;
            chk($sformatf("to%0d_ready", run), rdy_b, 1'b1);
            for (int k = 1; k <= 10; k++) begin
                step();
                in_valid = 1'b0;
                md_done  = (run == 1) && (k == 8);
                #1;
                chk($sformatf("to%0d_abort_c%0d", run, k), ab_b, (run == 0) && (k == 8));
                chk($sformatf("to%0d_start_c%0d", run, k), ms_b, k == 1);
                chk($sformatf("to%0d_valid_c%0d", run, k), ov_b, k == 9);
                if (k == 9) begin
                    chk($sformatf("to%0d_timeout", run), to_b, run == 0);
                    chk($sformatf("to%0d_sel_md", run), sel_b, 1'b1);
                end
            end
            md_done = 1'b0;
        end

        // Reset during MD_WAIT
        step();
        drive(2'b10, 3'd1, 7'b0000001, 1'b0);
        step();
        in_valid = 1'b0;
        #1;
        chk("rmid_md_start", ms_a, 1'b1);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("rmid_in_ready", rdy_a, 1'b0);
        chk("rmid_abort", ab_a, 1'b0);
        chk("rmid_valid", ov_a, 1'b0);
        chk("rmid_md_op", mop_a, 3'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rmid_rel_ready", rdy_a, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("rmid_quiet_%0d", k), {ab_a, ov_a, ms_a}, 3'b000);
        end

        // Backpressure: held output, in_valid high throughout
        out_ready = 1'b0;
        drive(2'b10, 3'd0, 7'h20, 1'b0);
        #1;
        chk("bp_first_ready", rdy_a, 1'b1);
        step();
        drive(2'b10, 3'd5, 7'h20, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk($sformatf("bp_valid_%0d", k), ov_a, 1'b1);
            chk($sformatf("bp_op_%0d", k), op_a, 4'b0110);
            chk($sformatf("bp_ready_%0d", k), rdy_a, 1'b0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", rdy_a, 1'b1);
        chk("bp_release_op", op_a, 4'b0110);
        step();
        in_valid = 1'b0;
        #1;
        chk("bp_second_valid", ov_a, 1'b1);
        chk("bp_second_op", op_a, 4'b1001);
        step();
        chk("bp_idle", ov_a, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Next-generation ALU control for the RV32 datapath: decodes ALU_Op/funct3/funct7 into the 4-bit ALU op code and adds the RV32M extension.
- Uses a valid/ready handshake on input and output, with registered outputs.
- Sequences multi-cycle mul/div operations through an external iterative unit via a start/done handshake, with a watchdog timeout.
- Flags illegal encodings instead of leaving op undefined.
- Sits between the decode stage and the execute stage.

Parameters:
- ENABLE_M, 1, decode funct7=7'b0000001 R-type ops as mul/div; when 0 these are illegal.
- MD_TIMEOUT, 64, maximum cycles to wait for md_done before abort (>=2).
- OP_W, 4, ALU op code width (fixed encoding below; values above 4 zero-extend).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode request valid.
- in_ready  out  1  block can accept a request.
- alu_op_i  in  2  00 load/store/AUIPC add, 01 branch, 10 arith R/I, 11 pass-B (LUI).
- funct3_i  in  3  instruction funct3.
- funct7_i  in  7  instruction funct7.
- is_imm_i  in  1  I-type arithmetic (funct7 is immediate bits).
- out_valid  out  1  registered result valid.
- out_ready  in  1  execute stage accepts result.
- out_op  out  OP_W  ALU op code.
- out_sel_md  out  1  result comes from mul/div unit.
- out_illegal  out  1  encoding illegal.
- out_timeout  out  1  mul/div aborted by watchdog.
- md_start  out  1  one-cycle start pulse to mul/div unit.
- md_op  out  3  mul/div funct3, held from md_start until done/abort.
- md_abort  out  1  one-cycle abort pulse.
- md_done  in  1  mul/div result ready (single-cycle pulse).

Behaviour:
- Encoding: AND 0000, OR 0001, ADD 0010, XOR 0101, SUB 0110, SRL 1000, SRA 1001, SLL 1010, SLT 1100, SLTU 1101, PASSB 1111.
- alu_op 00 -> ADD. alu_op 11 -> PASSB. Neither is ever illegal.
- Branch (alu_op 01): f3 0/1 -> SUB; 4/5 -> SLT; 6/7 -> SLTU; 2/3 illegal.
- Arith (alu_op 10), by funct3:
  - f3=0: SUB only if !is_imm and funct7=0100000, else ADD.
  - f3=5: SRA if funct7=0100000, else SRL.
  - Remaining funct3: 7 AND, 6 OR, 4 XOR, 3 SLTU, 2 SLT, 1 SLL.
- Legal funct7 for arith:
  - 0000000 always.
  - 0100000 only for (f3=0, !is_imm) or f3=5.
  - 0000001 only when !is_imm and ENABLE_M (this is an M op).
  - For I-type with f3 other than 1/5, funct7 is not checked.
- Illegal result: out_op=ADD, out_illegal=1, no md handshake.
- States: IDLE, MD_WAIT, OUT.
- in_ready = rst_n & (IDLE | (OUT & out_ready)). An accept is in_valid & in_ready.
- Accept, non-M op: registers out_op and flags; next state OUT; out_valid=1 the next cycle (latency 1). Back-to-back accepts from OUT give a throughput of 1 per cycle.
- Accept, M op: next cycle md_start=1 (exactly one cycle) and md_op=funct3. State MD_WAIT; out_valid=0; watchdog counter cleared.
- MD_WAIT:
  - Counter increments each cycle.
  - md_done=1 -> OUT with out_sel_md=1, out_op=ADD (don't-care), out_valid the next cycle.
  - If the counter reaches MD_TIMEOUT with no md_done -> md_abort pulse one cycle, then OUT with out_timeout=1, out_sel_md=1.
  - md_done in the same cycle as the timeout: done wins, no abort.
- OUT: out_valid and all out_* held stable until out_ready. On out_ready with no accept -> IDLE, out_valid=0.
- md_done outside MD_WAIT is ignored.
- Reset (async, any state, including mid MD_WAIT): state IDLE, all outputs 0, counter 0, in_ready 0 while rst_n low. No md_abort on reset, since the mul/div unit shares rst_n.
- Flags (out_illegal, out_timeout, out_sel_md) clear on every new accept.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALU op code localparams.
  - alu_op_i values.
  - funct7 constants: F7_BASE, F7_ALT, F7_MULDIV.
  - State enum.
- Sub-module alu_op_decode: purely combinational. Inputs alu_op/funct3/funct7/is_imm plus parameter ENABLE_M. Outputs op, is_md, illegal.
- alu_ctrl_seq holds the FSM, output registers and watchdog.

Test Plan:
- Reset: rst_n low -> all outputs 0 and in_ready 0. Release -> in_ready 1, out_valid 0.
- ALU ops, back-to-back with out_ready=1:
  - R-type f3=0 f7=0100000 -> 0110.
  - addi f3=0 is_imm=1 f7=0100000 -> 0010.
  - srai f3=5 f7=0100000 -> 1001.
  - Each result has out_valid one cycle after accept, one result per cycle.
- M op, ENABLE_M=1: f7=0000001 f3=4 (DIV) -> md_start pulse the cycle after accept, md_op=100. md_done at wait cycle 10 -> out_valid next cycle with out_sel_md=1. Same encoding with ENABLE_M=0 -> out_illegal=1, no md_start.
- Timeout, MD_TIMEOUT=8: md_done never asserted -> md_abort pulse 8 cycles into MD_WAIT, then out_valid with out_timeout=1. A second run with md_done coincident with the timeout cycle -> no abort, out_timeout=0.
- Backpressure: out_ready=0 for 5 cycles -> out_op stable and in_ready 0. in_valid held high the whole time -> accepted in the same cycle out_ready rises.
- Illegal and reset mid-operation:
  - Branch f3=2 -> out_illegal=1, out_op=0010.
  - rst_n pulsed during MD_WAIT -> IDLE, no md_abort, no out_valid.
